// File: rtl/jt10_adpcma_fetch.sv
// jt10_adpcma_fetch: ADPCM-A fetch front end for six time-multiplexed channels.
// Holds per-channel start/end pages and playback state, fetches ROM bytes over
// a single-outstanding request/ack handshake, and presents one nibble per slot.
// Build option: define JT10_ADPCMA_LOOP_EN to add the loop_en input; a looping
// channel reloads its start address at the end of the sample instead of stopping.
module jt10_adpcma_fetch #(
  parameter int AW  = 24,
  parameter int NCH = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic [2:0]    up_ch,
  input  logic          up_wr_start,
  input  logic          up_wr_end,
  input  logic [AW-9:0] up_addr,
  input  logic [5:0]    key_on,
  input  logic [5:0]    key_off,
  input  logic [5:0]    flag_clr,
`ifdef JT10_ADPCMA_LOOP_EN
  input  logic [5:0]    loop_en,
`endif
  output logic [AW-1:0] rom_addr,
  output logic          rom_cs,
  input  logic [7:0]    rom_data,
  input  logic          rom_ok,
  output logic [2:0]    slot,
  output logic [3:0]    data,
  output logic          chon,
  output logic          clr,
  output logic [5:0]    end_flags
);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_RUN, ST_END} ch_st_t;

  ch_st_t         st_q    [NCH];
  logic [AW-9:0]  start_q [NCH];
  logic [AW-9:0]  end_q   [NCH];
  logic [AW-1:0]  cur_q   [NCH];
  logic [7:0]     byte_q  [NCH];
  logic [NCH-1:0] bval_q;
  logic [NCH-1:0] nhi_q;
  logic [NCH-1:0] flags_q;

  logic [2:0]     slot_q;
  logic [3:0]     data_q;
  logic           chon_q;
  logic           clr_q;

  logic           cs_q;
  logic [AW-1:0]  addr_q;
  logic [2:0]     fch_q;
  logic [2:0]     last_q;
  logic           disc_q;

  logic [2:0]     slot_d;
  logic [NCH-1:0] kev, kon, loop_v;
  logic [NCH-1:0] slot_hit, at_end, hit_end, fill, cand;
  logic           pick_vld;
  logic [2:0]     pick_ch;

  assign kev    = key_on | key_off;
  assign kon    = key_on & ~key_off;
`ifdef JT10_ADPCMA_LOOP_EN
  assign loop_v = loop_en;
`else
  assign loop_v = '0;
`endif
  assign slot_d = (slot_q == 3'(NCH - 1)) ? 3'd0 : slot_q + 3'd1;

  // Per-channel qualifiers; a key event on a channel overrides its slot and fetch
  always_comb begin
    slot_hit = '0;
    at_end   = '0;
    hit_end  = '0;
    fill     = '0;
    cand     = '0;
    for (int c = 0; c < NCH; c++) begin
      slot_hit[c] = cen && (slot_d == 3'(c)) && !kev[c];
      at_end[c]   = (cur_q[c] == {end_q[c], 8'hFF});
      hit_end[c]  = slot_hit[c] && (st_q[c] == ST_RUN) && bval_q[c] && !nhi_q[c] && at_end[c];
      fill[c]     = cs_q && rom_ok && (fch_q == 3'(c)) && !disc_q && !kev[c];
      cand[c]     = ((st_q[c] == ST_RUN) || (st_q[c] == ST_START)) && !bval_q[c] && !kev[c];
    end
  end

  // Round-robin search for the next channel needing a byte, starting after the last grant
  always_comb begin
    pick_vld = 1'b0;
    pick_ch  = 3'd0;
    for (int k = 1; k <= NCH; k++) begin
      if (!pick_vld && cand[(int'(last_q) + k) % NCH]) begin
        pick_vld = 1'b1;
        pick_ch  = 3'((int'(last_q) + k) % NCH);
      end
    end
  end

  // Channel state machines, address registers and byte buffers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        st_q[c]    <= ST_IDLE;
        start_q[c] <= '0;
        end_q[c]   <= '0;
        cur_q[c]   <= '0;
        byte_q[c]  <= '0;
      end
      bval_q <= '0;
      nhi_q  <= '1;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (up_wr_start && up_ch == 3'(c)) start_q[c] <= up_addr;
        if (up_wr_end && up_ch == 3'(c))   end_q[c]   <= up_addr;
        if (fill[c]) begin
          byte_q[c] <= rom_data;
          bval_q[c] <= 1'b1;
        end
        if (key_off[c]) begin
          st_q[c]   <= ST_IDLE;
          bval_q[c] <= 1'b0;
        end else if (key_on[c]) begin
          st_q[c]   <= ST_START;
          cur_q[c]  <= {start_q[c], 8'h00};
          nhi_q[c]  <= 1'b1;
          bval_q[c] <= 1'b0;
        end else if (slot_hit[c]) begin
          if (st_q[c] == ST_START) begin
            st_q[c] <= ST_RUN;
          end else if (st_q[c] == ST_RUN && bval_q[c]) begin
            if (nhi_q[c]) begin
              nhi_q[c] <= 1'b0;
            end else begin
              nhi_q[c]  <= 1'b1;
              bval_q[c] <= 1'b0;
              if (at_end[c]) begin
                if (loop_v[c]) cur_q[c] <= {start_q[c], 8'h00};
                else           st_q[c]  <= ST_END;
              end else begin
                cur_q[c] <= cur_q[c] + 1'b1;
              end
            end
          end
        end
      end
    end
  end

  // Sticky end flags: setting beats a same-cycle clear, key-on clears its own flag
  always_ff @(posedge clk) begin
    if (!rst_n) flags_q <= '0;
    else        flags_q <= (flags_q & ~flag_clr & ~kon) | hit_end;
  end

  // Slot output stage, advanced only on cen
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_q <= '0;
      data_q <= '0;
      chon_q <= 1'b0;
      clr_q  <= 1'b0;
    end else if (cen) begin
      slot_q <= slot_d;
      data_q <= '0;
      chon_q <= 1'b0;
      clr_q  <= 1'b0;
      if (!kev[slot_d]) begin
        if (st_q[slot_d] == ST_START) begin
          clr_q <= 1'b1;
        end else if (st_q[slot_d] == ST_RUN && bval_q[slot_d]) begin
          chon_q <= 1'b1;
          data_q <= nhi_q[slot_d] ? byte_q[slot_d][7:4] : byte_q[slot_d][3:0];
        end
      end
    end
  end

  // ROM request engine; a key event on the channel in flight discards its byte
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs_q   <= 1'b0;
      addr_q <= '0;
      fch_q  <= '0;
      last_q <= 3'(NCH - 1);
      disc_q <= 1'b0;
    end else if (cs_q) begin
      if (kev[fch_q]) disc_q <= 1'b1;
      if (rom_ok)     cs_q   <= 1'b0;
    end else if (pick_vld) begin
      cs_q   <= 1'b1;
      addr_q <= cur_q[pick_ch];
      fch_q  <= pick_ch;
      last_q <= pick_ch;
      disc_q <= 1'b0;
    end
  end

  assign rom_addr  = addr_q;
  assign rom_cs    = cs_q;
  assign slot      = slot_q;
  assign data      = data_q;
  assign chon      = chon_q;
  assign clr       = clr_q;
  assign end_flags = flags_q;

endmodule

// File: tb/tb_jt10_adpcma_fetch.sv
// Testbench for jt10_adpcma_fetch: directed table of playback cases, hand-written
// corner sequences, and a randomized phase, all checked against a per-channel
// playback model (address pointer / nibble half / sticky flag) and a ROM function.
module tb_jt10_adpcma_fetch;
  localparam int AW = 24;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cen = 1'b0;
  logic [2:0]    up_ch = '0;
  logic          up_wr_start = 1'b0;
  logic          up_wr_end = 1'b0;
  logic [AW-9:0] up_addr = '0;
  logic [5:0]    key_on = '0;
  logic [5:0]    key_off = '0;
  logic [5:0]    flag_clr = '0;
  logic [5:0]    loop_en = '0;
  logic [AW-1:0] rom_addr;
  logic          rom_cs;
  logic [7:0]    rom_data;
  logic          rom_ok;
  logic [2:0]    slot;
  logic [3:0]    data;
  logic          chon;
  logic          clr;
  logic [5:0]    end_flags;

  jt10_adpcma_fetch #(.AW(AW), .NCH(6)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .up_ch(up_ch),
    .up_wr_start(up_wr_start), .up_wr_end(up_wr_end), .up_addr(up_addr),
    .key_on(key_on), .key_off(key_off), .flag_clr(flag_clr),
`ifdef JT10_ADPCMA_LOOP_EN
    .loop_en(loop_en),
`endif
    .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_data(rom_data), .rom_ok(rom_ok),
    .slot(slot), .data(data), .chon(chon), .clr(clr), .end_flags(end_flags)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ROM contents: mode 0 returns the low address byte, mode 1 a hash of all bytes
  int rom_mode = 0;
  function automatic logic [7:0] rom_f(input logic [23:0] a);
    if (rom_mode == 0) return a[7:0];
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
  endfunction

  // ROM responder: acks after a fixed or random number of clocks
  int rom_delay = 1;
  bit rom_rand = 0;
  initial begin
    int cnt;
    int d;
    cnt = 0;
    d = 1;
    rom_ok = 1'b0;
    rom_data = '0;
    forever begin
      @(negedge clk);
      if (rom_cs) begin
        if (cnt == 0) d = rom_rand ? int'($urandom_range(1, 8)) : rom_delay;
        cnt++;
        if (cnt >= d) begin
          rom_ok = 1'b1;
          rom_data = rom_f(rom_addr);
        end else begin
          rom_ok = 1'b0;
        end
      end else begin
        cnt = 0;
        rom_ok = 1'b0;
      end
    end
  end

  // cen generator: every cen_div clocks, or random
  int cen_div = 1;
  bit cen_rand = 0;
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(negedge clk);
      ph++;
      if (cen_rand) cen = 1'($urandom_range(0, 1));
      else          cen = ((ph % cen_div) == 0);
    end
  end

  // Playback model: 0 idle, 1 waiting for clr slot, 2 playing, 3 ended
  int          m_st   [6];
  logic [23:0] m_addr [6];
  bit          m_hi   [6];
  logic [15:0] m_start[6];
  logic [15:0] m_end  [6];
  logic [5:0]  m_flags;
  int          m_slot;
  int          nib_cnt[6];
  int          loops  [6];
  bit          ended_ev[6];
  int          underruns;
  int          trace_ch = -1;
  logic [3:0]  trace_q[$];

  initial begin
    logic [5:0]  kev, setv, lv;
    int          c;
    bit          exp_clr, can_play;
    logic [7:0]  b;
    logic [3:0]  nib;
    bit          prev_cs;
    logic [23:0] prev_addr;
    prev_cs = 0;
    prev_addr = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        for (int i = 0; i < 6; i++) begin
          m_st[i] = 0; m_addr[i] = '0; m_hi[i] = 1; m_start[i] = '0; m_end[i] = '0;
        end
        m_flags = '0;
        m_slot = 0;
        prev_cs = 0;
        chk("rst_outputs", {26'd0, slot, data, chon, clr}, 32'd0);
        chk("rst_rom", {7'd0, rom_cs, rom_addr}, 32'd0);
        chk("rst_flags", {26'd0, end_flags}, 32'd0);
      end else begin
        if (prev_cs) begin
          if (rom_ok) chk("cs_drop", {31'd0, rom_cs}, 32'd0);
          else        chk("addr_hold", {7'd0, rom_cs, rom_addr}, {7'd0, 1'b1, prev_addr});
        end
        prev_cs = rom_cs;
        prev_addr = rom_addr;
        kev = key_on | key_off;
`ifdef JT10_ADPCMA_LOOP_EN
        lv = loop_en;
`else
        lv = '0;
`endif
        setv = '0;
        if (cen) begin
          m_slot = (m_slot + 1) % 6;
          c = m_slot;
          chk("slot", {29'd0, slot}, c);
          exp_clr = (m_st[c] == 1) && !kev[c];
          can_play = (m_st[c] == 2) && !kev[c];
          chk("clr", {31'd0, clr}, {31'd0, exp_clr});
          if (chon) begin
            if (!can_play) begin
              chk("chon_allowed", {31'd0, chon}, 32'd0);
            end else begin
              b = rom_f(m_addr[c]);
              nib = m_hi[c] ? b[7:4] : b[3:0];
              chk("data", {28'd0, data}, {28'd0, nib});
              nib_cnt[c]++;
              if (c == trace_ch) trace_q.push_back(data);
              if (m_hi[c]) begin
                m_hi[c] = 0;
              end else begin
                m_hi[c] = 1;
                if (m_addr[c] == {m_end[c], 8'hFF}) begin
                  setv[c] = 1'b1;
                  ended_ev[c] = 1;
                  if (lv[c]) begin
                    m_addr[c] = {m_start[c], 8'h00};
                    loops[c]++;
                  end else begin
                    m_st[c] = 3;
                  end
                end else begin
                  m_addr[c] = m_addr[c] + 24'd1;
                end
              end
            end
          end else begin
            chk("data_idle", {28'd0, data}, 32'd0);
            if (can_play) underruns++;
          end
          if (exp_clr) m_st[c] = 2;
        end
        for (int i = 0; i < 6; i++) begin
          if (key_off[i]) m_st[i] = 0;
          else if (key_on[i]) begin
            m_st[i] = 1;
            m_addr[i] = {m_start[i], 8'h00};
            m_hi[i] = 1;
          end
        end
        if (up_wr_start && up_ch < 3'd6) m_start[up_ch] = up_addr;
        if (up_wr_end && up_ch < 3'd6)   m_end[up_ch] = up_addr;
        m_flags = (m_flags & ~flag_clr & ~(key_on & ~key_off)) | setv;
        chk("end_flags", {26'd0, end_flags}, {26'd0, m_flags});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic wr_addr(input int ch, input logic [15:0] s, input logic [15:0] e);
    up_ch = 3'(ch); up_addr = s; up_wr_start = 1'b1;
    tick(1);
    up_wr_start = 1'b0; up_addr = e; up_wr_end = 1'b1;
    tick(1);
    up_wr_end = 1'b0;
  endtask

  task automatic pulse_on(input logic [5:0] m);
    key_on = m;
    tick(1);
    key_on = '0;
  endtask

  task automatic clear_stats();
    for (int i = 0; i < 6; i++) begin
      nib_cnt[i] = 0; loops[i] = 0; ended_ev[i] = 0;
    end
    underruns = 0;
    trace_q.delete();
  endtask

  task automatic wait_end(input int ch, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ended_ev[ch]) begin
        ok = 1;
        break;
      end
    end
  endtask

  typedef struct {
    int          ch;
    logic [15:0] s;
    logic [15:0] e;
    int          rmode;
    int          exp_nib;
    logic [5:0]  exp_flags;
  } vec_t;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[3];
    int   exp6[6];
    bit   ok;
    int   nc, tot;
    logic [5:0] fl;
    logic [15:0] pg;

    tbl[0] = '{ch: 2, s: 16'h0012, e: 16'h0012, rmode: 0, exp_nib: 512,  exp_flags: 6'b000100};
    tbl[1] = '{ch: 5, s: 16'hFFFF, e: 16'h0000, rmode: 1, exp_nib: 1024, exp_flags: 6'b100000};
    tbl[2] = '{ch: 0, s: 16'h0100, e: 16'h0101, rmode: 1, exp_nib: 1024, exp_flags: 6'b000001};
    exp6 = '{0, 0, 0, 1, 0, 2};

    // Table-driven single-channel playback to the end of the sample
    for (int i = 0; i < 3; i++) begin
      do_reset();
      rom_mode = tbl[i].rmode; rom_delay = 1; rom_rand = 0; cen_div = 1; cen_rand = 0;
      clear_stats();
      trace_ch = tbl[i].ch;
      wr_addr(tbl[i].ch, tbl[i].s, tbl[i].e);
      pulse_on(6'(1 << tbl[i].ch));
      wait_end(tbl[i].ch, 9000, ok);
      chk("end_reached", {31'd0, ok}, 32'd1);
      tick(40);
      chk("nibble_count", nib_cnt[tbl[i].ch], tbl[i].exp_nib);
      chk("final_flags", {26'd0, end_flags}, {26'd0, tbl[i].exp_flags});
      $display("case %0d: ch=%0d start=%04h end=%04h nibbles=%0d flags=%06b", i, tbl[i].ch,
               tbl[i].s, tbl[i].e, nib_cnt[tbl[i].ch], end_flags);
      if (i == 0) begin
        chk("trace_len", {31'd0, trace_q.size() >= 6}, 32'd1);
        for (int k = 0; k < 6 && k < trace_q.size(); k++)
          chk("first_nibbles", {28'd0, trace_q[k]}, exp6[k]);
      end
    end
    trace_ch = -1;

    // Reset asserted while a request is outstanding
    do_reset();
    clear_stats();
    rom_mode = 1; rom_delay = 50;
    wr_addr(0, 16'h0200, 16'h0200);
    pulse_on(6'b000001);
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick(1);
      ok = rom_cs;
    end
    chk("req_seen", {31'd0, ok}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("cs_drop_on_reset", {31'd0, rom_cs}, 32'd0);
    tick(3);
    rst_n = 1'b1;
    rom_delay = 1;
    tick(30);
    chk("no_play_after_reset", nib_cnt[0], 32'd0);
    $display("reset mid-request: rom_cs=%0b slot=%0d", rom_cs, slot);

    // All channels on, slow ROM and cen every other clock: underruns without skips
    do_reset();
    clear_stats();
    rom_mode = 1; rom_delay = 8; cen_div = 2;
    for (int c = 0; c < 6; c++) begin
      pg = 16'($urandom_range(0, 16'hFFFE));
      wr_addr(c, pg, pg);
    end
    pulse_on(6'b111111);
    tick(800);
    for (int c = 0; c < 6; c++) chk("progress", {31'd0, nib_cnt[c] > 0}, 32'd1);
    chk("underruns_seen", {31'd0, underruns > 0}, 32'd1);
    $display("all channels: underruns=%0d nibbles ch0=%0d ch5=%0d", underruns, nib_cnt[0], nib_cnt[5]);

    // key_on and key_off together on a running channel
    nc = nib_cnt[1];
    fl = end_flags;
    key_on = 6'b000010; key_off = 6'b000010;
    tick(1);
    key_on = '0; key_off = '0;
    tick(40);
    chk("on_off_idle", nib_cnt[1], nc);
    chk("on_off_flags", {26'd0, end_flags}, {26'd0, fl});
    $display("key_on+key_off ch1: nibbles=%0d flags=%06b", nib_cnt[1], end_flags);

    // Randomized key traffic, flag clears, cen and ROM latency
    cen_rand = 1; rom_rand = 1;
    tot = 0;
    for (int i = 0; i < 2500; i++) begin
      key_on = '0; key_off = '0; flag_clr = '0;
      if ($urandom_range(0, 40) == 0) key_on[$urandom_range(0, 5)] = 1'b1;
      if ($urandom_range(0, 80) == 0) key_off[$urandom_range(0, 5)] = 1'b1;
      if ($urandom_range(0, 30) == 0) flag_clr = 6'($urandom);
      tick(1);
    end
    key_on = '0; key_off = '0; flag_clr = '0;
    for (int c = 0; c < 6; c++) tot += nib_cnt[c];
    chk("random_progress", {31'd0, tot > 0}, 32'd1);
    $display("random phase: total nibbles=%0d", tot);
    cen_rand = 0; rom_rand = 0; cen_div = 1;

    // End flag set while flag_clr is held: set wins, next clear takes effect
    do_reset();
    clear_stats();
    rom_mode = 0; rom_delay = 1;
    wr_addr(4, 16'h0044, 16'h0044);
    pulse_on(6'b010000);
    flag_clr = 6'b010000;
    wait_end(4, 5000, ok);
    chk("ch4_end", {31'd0, ok}, 32'd1);
    chk("set_beats_clear", {31'd0, end_flags[4]}, 32'd1);
    tick(1);
    chk("clear_next_clk", {31'd0, end_flags[4]}, 32'd0);
    flag_clr = '0;
    $display("flag set vs clear ch4: flags=%06b", end_flags);

`ifdef JT10_ADPCMA_LOOP_EN
    // Looping channel: reload start page, keep playing, flag raised
    do_reset();
    clear_stats();
    rom_mode = 1; rom_delay = 1; loop_en = 6'b000001;
    wr_addr(0, 16'h0030, 16'h0030);
    pulse_on(6'b000001);
    wait_end(0, 5000, ok);
    chk("loop_end", {31'd0, ok}, 32'd1);
    tick(1);
    chk("loop_flag", {31'd0, end_flags[0]}, 32'd1);
    tick(200);
    chk("loop_count", loops[0], 32'd1);
    chk("loop_continues", {31'd0, nib_cnt[0] > 512}, 32'd1);
    $display("loop ch0: nibbles=%0d loops=%0d", nib_cnt[0], loops[0]);
    loop_en = '0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
